mesm6_irq_dispatch: RTL and testbench

Bus-initiator counterpart to the `mesm6_pic` register port. It sits between the PIC and the CPU core. When the PIC raises `interrupt` and the core has interrupts enabled, it reads the PIC ISR register to get the winning source, then presents a bit-index vector to the core. After the core accepts the vector, it clears that source in the PIC via an IFSCLR write. Spurious wakeups (ISR reads back 0) are counted and dropped.

---
 rtl/mesm6_irq_dispatch.sv | 141 ++++++++++++++
 tb/tb_mesm6_irq_dispatch.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mesm6_irq_dispatch.sv
// mesm6_irq_dispatch: claims the winning PIC source via an ISR read, hands the
// bit-index vector to the core, then clears that source with an IFSCLR write.
module mesm6_irq_dispatch #(
    parameter logic [14:0] ADDR_ISR    = 15'o0,
    parameter logic [14:0] ADDR_IFSCLR = 15'o5,
    parameter int          CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             interrupt,
    input  logic             irq_enable,
    output logic [14:0]      pic_addr,
    output logic             pic_read,
    output logic             pic_write,
    input  logic [47:0]      pic_rdata,
    output logic [47:0]      pic_wdata,
    input  logic             pic_done,
    output logic             irq_req,
    output logic [5:0]       irq_vector,
    input  logic             irq_ack,
    output logic             busy,
    output logic [CNT_W-1:0] spurious_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ISR,
        PEND,
        WR_CLR,
        SETTLE
    } state_t;

    state_t           state_q, state_d;
    logic [14:0]      addr_q, addr_d;
    logic             rd_q, rd_d;
    logic             wr_q, wr_d;
    logic [47:0]      wdata_q, wdata_d;
    logic             req_q, req_d;
    logic [5:0]       vec_q, vec_d;
    logic [CNT_W-1:0] spur_q, spur_d;

    logic [5:0] isr;
    logic       isr_valid;

    // Nonzero upper read bits mean an ISR above 48, which is spurious.
    assign isr       = pic_rdata[5:0];
    assign isr_valid = (isr != 6'd0) && (isr <= 6'd48)
                     && (pic_rdata[47:6] == 42'd0);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        req_d   = req_q;
        vec_d   = vec_q;
        spur_d  = spur_q;
        unique case (state_q)
            IDLE: begin
                if (interrupt && irq_enable) begin
                    state_d = RD_ISR;
                    addr_d  = ADDR_ISR;
                    rd_d    = 1'b1;
                end
            end
            RD_ISR: begin
                if (pic_done) begin
                    rd_d = 1'b0;
                    if (isr_valid) begin
                        vec_d   = 6'd48 - isr;
                        req_d   = 1'b1;
                        state_d = PEND;
                    end else begin
                        if (spur_q != {CNT_W{1'b1}})
                            spur_d = spur_q + 1'b1;
                        state_d = SETTLE;
                    end
                end
            end
            PEND: begin
                if (irq_ack) begin
                    req_d   = 1'b0;
                    addr_d  = ADDR_IFSCLR;
                    wdata_d = 48'd1 << vec_q;
                    wr_d    = 1'b1;
                    state_d = WR_CLR;
                end
            end
            WR_CLR: begin
                if (pic_done) begin
                    wr_d    = 1'b0;
                    wdata_d = 48'd0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
                wdata_d = 48'd0;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= 15'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= 48'd0;
            req_q   <= 1'b0;
            vec_q   <= 6'd0;
            spur_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            req_q   <= req_d;
            vec_q   <= vec_d;
            spur_q  <= spur_d;
        end
    end

    assign pic_addr     = addr_q;
    assign pic_read     = rd_q;
    assign pic_write    = wr_q;
    assign pic_wdata    = wdata_q;
    assign irq_req      = req_q;
    assign irq_vector   = vec_q;
    assign busy         = (state_q != IDLE);
    assign spurious_cnt = spur_q;

endmodule

// File: tb/tb_mesm6_irq_dispatch.sv
// tb_mesm6_irq_dispatch: directed bench with a small behavioural PIC model
// (IFS/IEC, lowest-index-wins ISR, IFSCLR, configurable done delay).
module tb_mesm6_irq_dispatch;

    logic        clk = 1'b0;
    logic        reset;
    logic        pic_int;
    logic        irq_enable;
    logic [14:0] pic_addr;
    logic        pic_read;
    logic        pic_write;
    logic [47:0] pic_rdata;
    logic [47:0] pic_wdata;
    logic        pic_done;
    logic        irq_req;
    logic [5:0]  irq_vector;
    logic        irq_ack;
    logic        busy;
    logic [15:0] spurious_cnt;

    always #5 clk = ~clk;

    mesm6_irq_dispatch dut (
        .clk          (clk),
        .reset        (reset),
        .interrupt    (pic_int),
        .irq_enable   (irq_enable),
        .pic_addr     (pic_addr),
        .pic_read     (pic_read),
        .pic_write    (pic_write),
        .pic_rdata    (pic_rdata),
        .pic_wdata    (pic_wdata),
        .pic_done     (pic_done),
        .irq_req      (irq_req),
        .irq_vector   (irq_vector),
        .irq_ack      (irq_ack),
        .busy         (busy),
        .spurious_cnt (spurious_cnt)
    );

    // PIC model state; the bench only writes iec/ifs_set/force_spur/spur_isr/dly.
    logic [47:0] ifs = '0;
    logic [47:0] iec = '0;
    logic [47:0] ifs_set = '0;
    logic        force_spur = 1'b0;
    logic [47:0] spur_isr = '0;
    int          dly = 0;
    int          wait_cnt = 0;
    int          n_rd = 0;
    int          n_wr = 0;
    int          stab_err = 0;
    int          proto_err = 0;
    logic        prev_rd = 1'b0;
    logic        prev_wr = 1'b0;
    logic        prev_done = 1'b0;
    logic [14:0] prev_addr = '0;
    logic [47:0] prev_wdata = '0;

    function automatic logic [47:0] isr_of(input logic [47:0] act,
                                           input logic [47:0] dflt);
        for (int i = 0; i < 48; i++)
            if (act[i]) return 48'(48 - i);
        return dflt;
    endfunction

    initial begin
        pic_int   = 1'b0;
        pic_done  = 1'b0;
        pic_rdata = '0;
    end

    always @(posedge clk) begin
        logic [47:0] clr;
        clr = '0;
        pic_done <= 1'b0;
        if ((pic_read || pic_write) && !pic_done) begin
            if (wait_cnt >= dly) begin
                wait_cnt <= 0;
                pic_done <= 1'b1;
                if (pic_read) begin
                    n_rd++;
                    if (pic_addr == 15'o0)
                        pic_rdata <= isr_of(ifs & iec, spur_isr);
                end
                if (pic_write) begin
                    n_wr++;
                    if (pic_addr == 15'o5) clr = pic_wdata;
                end
            end else begin
                wait_cnt <= wait_cnt + 1;
            end
        end
        ifs     <= (ifs | ifs_set) & ~clr;
        pic_int <= force_spur || ((ifs & iec) != '0);
        if (pic_read && pic_write) proto_err++;
        if (!pic_write && pic_wdata != '0) proto_err++;
        if (((pic_read && prev_rd) || (pic_write && prev_wr)) && !prev_done)
            if (pic_addr != prev_addr || pic_wdata != prev_wdata) stab_err++;
        prev_rd    <= pic_read;
        prev_wr    <= pic_write;
        prev_done  <= pic_done;
        prev_addr  <= pic_addr;
        prev_wdata <= pic_wdata;
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_ifs(input logic [47:0] v);
        ifs_set = v;
        step();
        ifs_set = '0;
    endtask

    task automatic wait_read(input string tag, input int max);
        int n = 0;
        while (!pic_read && n < max) begin
            step();
            n++;
        end
        chk(tag, 64'(pic_read), 64'd1);
    endtask

    task automatic wait_req(input string tag, input int max);
        int n = 0;
        while (!irq_req && n < max) begin
            step();
            n++;
        end
        chk(tag, 64'(irq_req), 64'd1);
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n = 0;
        while (busy && n < max) begin
            step();
            n++;
        end
        chk(tag, 64'(busy), 64'd0);
    endtask

    task automatic ack();
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
    endtask

    int rd0, wr0, spur0;

    initial begin
        reset      = 1'b1;
        irq_enable = 1'b1;
        irq_ack    = 1'b0;
        force_spur = 1'b1;
        step(3);
        chk("rst_read", 64'(pic_read), 64'd0);
        chk("rst_write", 64'(pic_write), 64'd0);
        chk("rst_req", 64'(irq_req), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_addr", 64'(pic_addr), 64'd0);
        chk("rst_wdata", 64'(pic_wdata), 64'd0);
        chk("rst_vec", 64'(irq_vector), 64'd0);
        chk("rst_spur", 64'(spurious_cnt), 64'd0);
        irq_enable = 1'b0;
        reset      = 1'b0;
        step(4);
        chk("gated_read", 64'(pic_read), 64'd0);
        chk("gated_busy", 64'(busy), 64'd0);
        force_spur = 1'b0;
        step(3);

        // single source, bit 9
        iec = 48'd1 << 9;
        irq_enable = 1'b1;
        set_ifs(48'd1 << 9);
        wait_read("s_read", 10);
        chk("s_rd_addr", 64'(pic_addr), 64'd0);
        step();
        chk("s_lat_early", 64'(irq_req), 64'd0);
        step();
        chk("s_lat", 64'(irq_req), 64'd1);
        chk("s_vec", 64'(irq_vector), 64'd9);
        chk("s_rd_drop", 64'(pic_read), 64'd0);
        step(3);
        chk("s_req_hold", 64'(irq_req), 64'd1);
        ack();
        chk("s_req_drop", 64'(irq_req), 64'd0);
        chk("s_write", 64'(pic_write), 64'd1);
        chk("s_wr_addr", 64'(pic_addr), 64'd5);
        chk("s_wdata", 64'(pic_wdata), 64'(48'd1 << 9));
        wait_idle("s_idle", 10);
        step(2);
        chk("s_ifs", 64'(ifs), 64'd0);
        chk("s_int", 64'(pic_int), 64'd0);
        chk("s_nrd", 64'(n_rd), 64'd1);
        chk("s_nwr", 64'(n_wr), 64'd1);

        // two sources: lower index wins
        iec = (48'd1 << 9) | (48'd1 << 19);
        set_ifs((48'd1 << 9) | (48'd1 << 19));
        wait_req("t_req1", 20);
        chk("t_vec1", 64'(irq_vector), 64'd9);
        ack();
        wait_req("t_req2", 20);
        chk("t_vec2", 64'(irq_vector), 64'd19);
        ack();
        chk("t_wdata2", 64'(pic_wdata), 64'(48'd1 << 19));
        wait_idle("t_idle", 10);
        step(3);
        chk("t_ifs", 64'(ifs), 64'd0);
        chk("t_busy", 64'(busy), 64'd0);

        // spurious: ISR 0, then ISR 50
        wr0 = n_wr;
        force_spur = 1'b1;
        wait_read("sp_read", 10);
        force_spur = 1'b0;
        wait_idle("sp_idle", 10);
        chk("sp_cnt", 64'(spurious_cnt), 64'd1);
        chk("sp_req", 64'(irq_req), 64'd0);
        step(3);
        spur_isr = 48'd50;
        force_spur = 1'b1;
        wait_read("sp50_read", 10);
        force_spur = 1'b0;
        wait_idle("sp50_idle", 10);
        spur_isr = '0;
        chk("sp50_cnt", 64'(spurious_cnt), 64'd2);
        chk("sp_nwr", 64'(n_wr), 64'(wr0));
        step(3);

        // slow PIC, bit 3 (ISR 45)
        dly = 5;
        rd0 = n_rd;
        wr0 = n_wr;
        spur0 = stab_err;
        iec = 48'd1 << 3;
        set_ifs(48'd1 << 3);
        wait_req("sl_req", 30);
        chk("sl_vec", 64'(irq_vector), 64'd3);
        ack();
        wait_idle("sl_idle", 30);
        step(3);
        chk("sl_stable", 64'(stab_err), 64'(spur0));
        chk("sl_nrd", 64'(n_rd - rd0), 64'd1);
        chk("sl_nwr", 64'(n_wr - wr0), 64'd1);
        chk("sl_ifs", 64'(ifs), 64'd0);
        dly = 0;

        // reset in PEND aborts without clearing
        iec = 48'd1 << 7;
        set_ifs(48'd1 << 7);
        wait_req("ab_req", 20);
        wr0 = n_wr;
        reset = 1'b1;
        step();
        irq_enable = 1'b0;
        reset = 1'b0;
        chk("ab_req_drop", 64'(irq_req), 64'd0);
        chk("ab_busy", 64'(busy), 64'd0);
        step(3);
        chk("ab_ifs", 64'(ifs[7]), 64'd1);
        chk("ab_nwr", 64'(n_wr), 64'(wr0));

        // dropping irq_enable in PEND keeps the claim
        irq_enable = 1'b1;
        wait_req("g_req", 20);
        irq_enable = 1'b0;
        step(4);
        chk("g_hold", 64'(irq_req), 64'd1);
        chk("g_vec", 64'(irq_vector), 64'd7);
        ack();
        wait_idle("g_idle", 10);
        step(2);
        chk("g_ifs", 64'(ifs), 64'd0);
        chk("proto", 64'(proto_err), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
